// File: rtl/uart_byte_streamer.sv
// rtl/uart_byte_streamer.sv - 8N1 UART serializer for the repeater byte stream with per-number byte counting
module uart_byte_streamer #(
  parameter int CLOCK_FREQ  = 100_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int BITS_IN_NUM = 4096
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic [7:0]                           data_in,
  input  logic                                 valid_in,
  output logic                                 request_next_byte_out,
  output logic                                 tx_out,
  output logic                                 busy_out,
  output logic [$clog2(BITS_IN_NUM/8)-1:0]     byte_count_out,
  output logic                                 num_done_out
);

  localparam int CPB           = CLOCK_FREQ / BAUD_RATE;
  localparam int BYTES_PER_NUM = BITS_IN_NUM / 8;
  localparam int CNT_W         = $clog2(CPB);
  localparam int CW            = $clog2(BYTES_PER_NUM);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift_q, shift_n;
  logic             tx_n;
  logic [CW-1:0]    count_n;
  logic             wrap_q, wrap_n;
  logic             done_n;
  logic             last_bit;
  logic             accept;

  assign last_bit = (bit_cnt == CNT_W'(CPB - 1));
  // Gated by reset so the upstream stage never sees a request while held in reset.
  assign accept = rst_in && valid_in &&
                  ((state == IDLE) || ((state == STOP) && last_bit));
  assign request_next_byte_out = accept;
  assign busy_out = (state != IDLE);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      bit_idx        <= '0;
      shift_q        <= '0;
      tx_out         <= 1'b1;
      byte_count_out <= '0;
      wrap_q         <= 1'b0;
      num_done_out   <= 1'b0;
    end else begin
      state          <= state_n;
      bit_cnt        <= bit_cnt_n;
      bit_idx        <= bit_idx_n;
      shift_q        <= shift_n;
      tx_out         <= tx_n;
      byte_count_out <= count_n;
      wrap_q         <= wrap_n;
      num_done_out   <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = last_bit ? '0 : bit_cnt + CNT_W'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift_q;
    tx_n      = tx_out;
    count_n   = byte_count_out;
    wrap_n    = wrap_q;
    done_n    = 1'b0;

    case (state)
      IDLE: begin
        bit_cnt_n = '0;
        tx_n      = 1'b1;
      end
      START: begin
        if (last_bit) begin
          tx_n      = shift_q[0];
          shift_n   = {1'b1, shift_q[7:1]};
          bit_idx_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        // shift_q[0] always holds the bit that follows the one on the line.
        if (last_bit) begin
          shift_n = {1'b1, shift_q[7:1]};
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            tx_n      = shift_q[0];
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (last_bit) begin
          done_n  = wrap_q;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // A chained accept overrides the STOP exit but keeps the completing byte's done pulse.
    if (accept) begin
      shift_n   = data_in;
      tx_n      = 1'b0;
      bit_cnt_n = '0;
      state_n   = START;
      count_n   = byte_count_out + CW'(1);
      wrap_n    = (byte_count_out == CW'(BYTES_PER_NUM - 1));
    end
  end

endmodule
